// File: rtl/fetch_stage_pkg.sv
// Shared pipeline constants and the fetch-state encoding used by the
// instruction-fetch stage.
package fetch_stage_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response handshake between the fetch stage
// (master) and instruction memory (slave).
interface fetch_stage_if #(
  parameter int XLEN = 32
) ();

  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [31:0]     rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/fetch_stage_if_dx_reg.sv
// IF/DX pipeline register: flush beats hold, hold beats load, and anything
// else drops a bubble in while keeping the last PC for trace.
module if_dx_reg
  import fetch_stage_pkg::*;
#(
  parameter int          XLEN     = fetch_stage_pkg::XLEN,
  parameter logic [31:0] NOP_INST = fetch_stage_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            hold,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  input  logic [31:0]     load_inst,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     inst,
  output logic            valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= '0;
      inst  <= NOP_INST;
      valid <= 1'b0;
    end else if (flush) begin
      inst  <= NOP_INST;
      valid <= 1'b0;
    end else if (!hold) begin
      if (load) begin
        pc    <= load_pc;
        inst  <= load_inst;
        valid <= 1'b1;
      end else begin
        inst  <= NOP_INST;
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps a single outstanding imem
// request, parks one response while stalled and feeds the IF/DX register.
//
// state   | meaning
// S_RESET | first cycle after reset, no request
// S_REQ   | request pc_q, waiting for gnt
// S_WAIT  | granted, waiting for rvalid (kill_q marks a wrong-path fetch)
// S_HOLD  | response parked in the buffer until the stall drops
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              XLEN     = fetch_stage_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = fetch_stage_pkg::RESET_PC,
  parameter logic [31:0]     NOP_INST = fetch_stage_pkg::NOP_INST
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_stage_if.master        imem,
  input  logic                 br_taken,
  input  logic [XLEN-1:0]      br_target,
  input  logic                 stall_if,
  input  logic                 stall_dx,
  output logic [XLEN-1:0]      pc_if,
  output logic [XLEN-1:0]      pc_dx,
  output logic [31:0]          inst_dx,
  output logic                 valid_dx
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;
  logic            kill_q;
  logic            buf_valid;
  logic [XLEN-1:0] buf_pc;
  logic [31:0]     buf_inst;
  logic            seen_gnt_q;

  logic            stall;
  logic            rsp_load;
  logic            buf_load;
  logic [XLEN-1:0] load_pc;
  logic [31:0]     load_inst;

  assign stall = stall_if | stall_dx;

  assign imem.req  = (state == S_REQ);
  assign imem.addr = pc_q;
  assign pc_if     = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RESET;
      pc_q      <= RESET_PC;
      req_pc_q  <= '0;
      kill_q    <= 1'b0;
      buf_valid <= 1'b0;
      buf_pc    <= '0;
      buf_inst  <= NOP_INST;
    end else begin
      if (br_taken) pc_q <= br_target;
      unique case (state)
        S_RESET: state <= S_REQ;
        S_REQ: begin
          if (imem.gnt) begin
            state    <= S_WAIT;
            req_pc_q <= pc_q;
            if (br_taken) kill_q <= 1'b1;
            else          pc_q   <= pc_q + XLEN'(4);
          end
        end
        S_WAIT: begin
          if (imem.rvalid) begin
            kill_q <= 1'b0;
            if (br_taken || kill_q) begin
              state <= S_REQ;
            end else if (stall) begin
              buf_valid <= 1'b1;
              buf_pc    <= req_pc_q;
              buf_inst  <= imem.rdata;
              state     <= S_HOLD;
            end else begin
              state <= S_REQ;
            end
          end else if (br_taken) begin
            kill_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (br_taken || !stall) begin
            buf_valid <= 1'b0;
            state     <= S_REQ;
          end
        end
      endcase
    end
  end

  // Only arms the protocol check once a request has actually been granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          seen_gnt_q <= 1'b0;
    else if (state == S_REQ && imem.gnt) seen_gnt_q <= 1'b1;
  end

  assign rsp_load  = (state == S_WAIT) && imem.rvalid && !kill_q && !br_taken && !stall;
  assign buf_load  = (state == S_HOLD) && buf_valid && !br_taken && !stall;
  assign load_pc   = (state == S_HOLD) ? buf_pc : req_pc_q;
  assign load_inst = (state == S_HOLD) ? buf_inst : imem.rdata;

  if_dx_reg #(
    .XLEN     (XLEN),
    .NOP_INST (NOP_INST)
  ) u_if_dx_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (br_taken),
    .hold      (stall_dx),
    .load      (rsp_load | buf_load),
    .load_pc   (load_pc),
    .load_inst (load_inst),
    .pc        (pc_dx),
    .inst      (inst_dx),
    .valid     (valid_dx)
  );

  a_rvalid_in_wait: assert property (
    @(posedge clk) disable iff (!rst_n)
      (imem.rvalid && seen_gnt_q) |-> (state == S_WAIT)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: cycle-exact vector table for the directed corners,
// then a random memory/stall/branch run checked against an in-order queue.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        stall_if = 1'b0;
  logic        stall_dx = 1'b0;
  logic [31:0] pc_if, pc_dx, inst_dx;
  logic        valid_dx;

  fetch_stage_if #(.XLEN(32)) imem ();

  fetch_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem      (imem),
    .br_taken  (br_taken),
    .br_target (br_target),
    .stall_if  (stall_if),
    .stall_dx  (stall_dx),
    .pc_if     (pc_if),
    .pc_dx     (pc_dx),
    .inst_dx   (inst_dx),
    .valid_dx  (valid_dx)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        gnt;
    logic        rvalid;
    logic [31:0] raddr;
    logic        sif;
    logic        sdx;
    logic        br;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  vec_t tbl [0:22];
  exp_t sb_q [$];
  int   total = 0;
  int   bad = 0;
  int   delivered = 0;

  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = '0;
  logic        prev_sdx = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:2], 2'b11};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic gnt, input logic rv, input logic [31:0] raddr,
                         input logic sif, input logic sdx, input logic br, input logic [31:0] tgt,
                         input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                         input logic [31:0] e_pc, input logic [31:0] e_inst);
    tbl[i] = '{gnt, rv, raddr, sif, sdx, br, tgt, e_req, e_addr, e_valid, e_pc, e_inst};
  endtask

  // One negedge of random memory + control traffic, with scoreboard upkeep.
  task automatic rand_step(input logic quiet);
    logic [31:0] a;
    if (valid_dx && !prev_sdx) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got pc %h inst %h want none", pc_dx, inst_dx);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_pc", pc_dx, e.pc);
        chk("sb_inst", inst_dx, e.inst);
        delivered++;
      end
    end
    imem.gnt    = 1'b0;
    imem.rvalid = 1'b0;
    if (pend) begin
      if (cnt == 0) begin
        imem.rvalid = 1'b1;
        imem.rdata  = mem_word(paddr);
        pend        = 1'b0;
      end else begin
        cnt--;
      end
    end else if (imem.req && $urandom_range(0, 2) != 0) begin
      imem.gnt = 1'b1;
      pend     = 1'b1;
      paddr    = imem.addr;
      cnt      = int'($urandom_range(0, 2));
    end
    a         = $urandom;
    stall_if  = !quiet && ($urandom_range(0, 3) == 0);
    stall_dx  = !quiet && ($urandom_range(0, 3) == 0);
    br_taken  = !quiet && ($urandom_range(0, 11) == 0);
    br_target = {20'h0, a[11:2], 2'b00};
    if (br_taken) sb_q.delete();
    else if (imem.gnt) sb_q.push_back('{imem.addr, mem_word(imem.addr)});
    prev_sdx = stall_dx;
  endtask

  initial begin
    imem.gnt    = 1'b0;
    imem.rvalid = 1'b0;
    imem.rdata  = '0;

    //          i  gnt rv raddr      sif sdx br tgt        req addr       vld pc         inst
    set_vec( 0, 0, 0, 32'h0,      0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      NOP);
    set_vec( 1, 1, 0, 32'h0,      0, 0, 0, 32'h0,      1, 32'h0,      0, 32'h0,      NOP);
    set_vec( 2, 0, 1, 32'h0,      0, 0, 0, 32'h0,      0, 32'h4,      0, 32'h0,      NOP);
    set_vec( 3, 1, 0, 32'h0,      0, 0, 0, 32'h0,      1, 32'h4,      1, 32'h0,      mem_word(32'h0));
    set_vec( 4, 0, 1, 32'h4,      0, 0, 0, 32'h0,      0, 32'h8,      0, 32'h0,      NOP);
    set_vec( 5, 1, 0, 32'h0,      0, 0, 0, 32'h0,      1, 32'h8,      1, 32'h4,      mem_word(32'h4));
    set_vec( 6, 0, 1, 32'h8,      1, 1, 0, 32'h0,      0, 32'hC,      0, 32'h4,      NOP);
    set_vec( 7, 0, 0, 32'h0,      1, 1, 0, 32'h0,      0, 32'hC,      0, 32'h4,      NOP);
    set_vec( 8, 0, 0, 32'h0,      1, 1, 0, 32'h0,      0, 32'hC,      0, 32'h4,      NOP);
    set_vec( 9, 0, 0, 32'h0,      0, 0, 0, 32'h0,      0, 32'hC,      0, 32'h4,      NOP);
    set_vec(10, 1, 0, 32'h0,      0, 0, 0, 32'h0,      1, 32'hC,      1, 32'h8,      mem_word(32'h8));
    set_vec(11, 0, 0, 32'h0,      0, 0, 1, 32'h100,    0, 32'h10,     0, 32'h8,      NOP);
    set_vec(12, 0, 0, 32'h0,      0, 0, 0, 32'h0,      0, 32'h100,    0, 32'h8,      NOP);
    set_vec(13, 0, 1, 32'hC,      0, 0, 0, 32'h0,      0, 32'h100,    0, 32'h8,      NOP);
    set_vec(14, 1, 0, 32'h0,      0, 0, 0, 32'h0,      1, 32'h100,    0, 32'h8,      NOP);
    set_vec(15, 0, 1, 32'h100,    0, 0, 0, 32'h0,      0, 32'h104,    0, 32'h8,      NOP);
    set_vec(16, 0, 0, 32'h0,      0, 1, 1, 32'h200,    1, 32'h104,    1, 32'h100,    mem_word(32'h100));
    set_vec(17, 0, 0, 32'h0,      0, 0, 1, 32'h20,     1, 32'h200,    0, 32'h100,    NOP);
    set_vec(18, 1, 0, 32'h0,      0, 0, 1, 32'h40,     1, 32'h20,     0, 32'h100,    NOP);
    set_vec(19, 0, 1, 32'h20,     0, 0, 0, 32'h0,      0, 32'h40,     0, 32'h100,    NOP);
    set_vec(20, 1, 0, 32'h0,      0, 0, 0, 32'h0,      1, 32'h40,     0, 32'h100,    NOP);
    set_vec(21, 0, 1, 32'h40,     0, 0, 0, 32'h0,      0, 32'h44,     0, 32'h100,    NOP);
    set_vec(22, 1, 0, 32'h0,      0, 0, 0, 32'h0,      1, 32'h44,     1, 32'h40,     mem_word(32'h40));

    @(negedge clk);
    chk("rst_req", 32'(imem.req), 32'h0);
    chk("rst_addr", imem.addr, 32'h0);
    chk("rst_pc_if", pc_if, 32'h0);
    chk("rst_valid", 32'(valid_dx), 32'h0);
    chk("rst_pc_dx", pc_dx, 32'h0);
    chk("rst_inst", inst_dx, NOP);
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      chk($sformatf("v%0d.req", i), 32'(imem.req), 32'(tbl[i].e_req));
      chk($sformatf("v%0d.addr", i), imem.addr, tbl[i].e_addr);
      chk($sformatf("v%0d.valid", i), 32'(valid_dx), 32'(tbl[i].e_valid));
      chk($sformatf("v%0d.pc_dx", i), pc_dx, tbl[i].e_pc);
      chk($sformatf("v%0d.inst", i), inst_dx, tbl[i].e_inst);
      imem.gnt    = tbl[i].gnt;
      imem.rvalid = tbl[i].rvalid;
      imem.rdata  = tbl[i].rvalid ? mem_word(tbl[i].raddr) : 32'h0;
      stall_if    = tbl[i].sif;
      stall_dx    = tbl[i].sdx;
      br_taken    = tbl[i].br;
      br_target   = tbl[i].tgt;
      @(negedge clk);
    end

    // Reset in the middle of a granted fetch (now in S_WAIT for 0x44).
    imem.gnt    = 1'b0;
    imem.rvalid = 1'b0;
    stall_if    = 1'b0;
    stall_dx    = 1'b0;
    br_taken    = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(imem.req), 32'h0);
    chk("mid_rst_addr", imem.addr, 32'h0);
    chk("mid_rst_valid", 32'(valid_dx), 32'h0);
    chk("mid_rst_pc_dx", pc_dx, 32'h0);
    chk("mid_rst_inst", inst_dx, NOP);
    @(negedge clk);
    rst_n       = 1'b1;
    imem.rvalid = 1'b1;
    imem.rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem.rvalid = 1'b0;
    chk("post_rst_req", 32'(imem.req), 32'h1);
    chk("post_rst_addr", imem.addr, 32'h0);
    chk("post_rst_valid", 32'(valid_dx), 32'h0);

    for (int c = 0; c < 3000; c++) begin
      rand_step(1'b0);
      @(negedge clk);
    end
    for (int c = 0; c < 100 && (sb_q.size() != 0 || pend); c++) begin
      rand_step(1'b1);
      @(negedge clk);
    end
    rand_step(1'b1);
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    total++;
    if (delivered < 100) begin
      bad++;
      $display("FAIL sb_delivered: got %0d want >=100", delivered);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
